// File: rtl/gray_pkg.sv
// Shared types and defaults for the RGB-to-grayscale stream controller.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } gray_state_e;

    typedef struct packed {
        logic [7:0] gray;
        logic       eol;
        logic       eof;
    } gray_entry_t;

    localparam int GRAY_WIDTH_DEF    = 640;
    localparam int GRAY_HEIGHT_DEF   = 480;
    localparam int GRAY_PIPE_LAT_DEF = 3;

endpackage

// File: rtl/gray_out_fifo.sv
// Output FIFO holding gray results with their line/frame markers.
module gray_out_fifo
    import gray_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  gray_entry_t              wdata,
    input  logic                     pop,
    output gray_entry_t              head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    gray_entry_t   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/gray_stream_ctrl.sv
// Frame-sequencing stream controller around a fixed-latency grayscale datapath.
// Optional stall counter output enabled by defining GRAY_CTRL_STATS_EN.
module gray_stream_ctrl
    import gray_pkg::*;
#(
    parameter int WIDTH      = GRAY_WIDTH_DEF,
    parameter int HEIGHT     = GRAY_HEIGHT_DEF,
    parameter int PIPE_LAT   = GRAY_PIPE_LAT_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    output logic [7:0]  dp_r,
    output logic [7:0]  dp_g,
    output logic [7:0]  dp_b,
    input  logic [7:0]  dp_gray,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_gray,
    output logic        out_eol,
    output logic        out_eof,
    output logic        busy,
    output logic        frame_done
`ifdef GRAY_CTRL_STATS_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(PIPE_LAT + 2);
    localparam int SW = CW + 1;

    gray_state_e   state;
    gray_state_e   state_next;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [PIPE_LAT:0] vld_pipe;
    logic [PIPE_LAT:0] eol_pipe;
    logic [PIPE_LAT:0] eof_pipe;
    logic [IW-1:0] inflight;
    logic [SW-1:0] occupancy;
    logic [CW-1:0] fifo_count;
    gray_entry_t   fifo_head;
    gray_entry_t   fifo_wdata;
    logic          accept;
    logic          pop;
    logic          last_x;
    logic          last_y;
    logic          chain_empty;
    logic          fifo_last;

    assign last_x      = (x == XW'(WIDTH - 1));
    assign last_y      = (y == YW'(HEIGHT - 1));
    assign chain_empty = (vld_pipe == '0);

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= PIPE_LAT; i++) begin
            inflight = inflight + IW'(vld_pipe[i]);
        end
    end

    // Every accepted pixel holds a credit until popped, so the datapath never stalls.
    assign occupancy = SW'(inflight) + SW'(fifo_count);
    assign in_ready  = (state == RUN) && (occupancy < SW'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign fifo_last = (fifo_count == '0) || ((fifo_count == CW'(1)) && pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && last_x && last_y) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (chain_empty && fifo_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if ((state == IDLE) && start) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (last_x) begin
                x <= '0;
                y <= last_y ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Issue stage: pixel registered toward the datapath, validity enters the shadow chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_r     <= '0;
            dp_g     <= '0;
            dp_b     <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PIPE_LAT-1:0], accept};
            if (accept) begin
                dp_r <= in_r;
                dp_g <= in_g;
                dp_b <= in_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        eol_pipe <= {eol_pipe[PIPE_LAT-1:0], last_x};
        eof_pipe <= {eof_pipe[PIPE_LAT-1:0], last_x && last_y};
    end

    // Capture stage: the chain tap lines up with a meaningful dp_gray.
    assign fifo_wdata = '{gray: dp_gray, eol: eol_pipe[PIPE_LAT], eof: eof_pipe[PIPE_LAT]};

    gray_out_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .wr   (vld_pipe[PIPE_LAT]),
        .wdata(fifo_wdata),
        .pop  (pop),
        .head (fifo_head),
        .count(fifo_count)
    );

    assign out_gray = out_valid ? fifo_head.gray : '0;
    assign out_eol  = out_valid && fifo_head.eol;
    assign out_eof  = out_valid && fifo_head.eof;

`ifdef GRAY_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cycles <= '0;
        end else if ((state == RUN) && in_valid && !in_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_stream_ctrl.sv
// Randomized bench for gray_stream_ctrl with a credit/queue reference model and a shift-add datapath stub.
module tb_gray_stream_ctrl;

    localparam int W = 4;
    localparam int H = 4;
    localparam int L = 3;
    localparam int D = 8;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_r = '0;
    logic [7:0] in_g = '0;
    logic [7:0] in_b = '0;
    logic [7:0] dp_gray;
    logic       in_ready;
    logic [7:0] dp_r, dp_g, dp_b;
    logic       out_valid, out_eol, out_eof, busy, frame_done;
    logic [7:0] out_gray;
`ifdef GRAY_CTRL_STATS_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    gray_stream_ctrl #(
        .WIDTH(W), .HEIGHT(H), .PIPE_LAT(L), .FIFO_DEPTH(D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .dp_r      (dp_r),
        .dp_g      (dp_g),
        .dp_b      (dp_b),
        .dp_gray   (dp_gray),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .busy      (busy),
        .frame_done(frame_done)
`ifdef GRAY_CTRL_STATS_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    function automatic logic [7:0] gray_ref(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int s;
        s = int'(r >> 2) + int'(r >> 5) + int'(g >> 1) + int'(g >> 4) + int'(g >> 7)
          + int'(b >> 3) + int'(b >> 6);
        return 8'(s);
    endfunction

    // Shift-add datapath stand-in: L register stages after the issued pixel.
    logic [7:0] dp_pipe [L];
    always_ff @(posedge clk) begin
        dp_pipe[0] <= gray_ref(dp_r, dp_g, dp_b);
        for (int i = 1; i < L; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_gray = dp_pipe[L-1];

    typedef struct {
        logic [7:0] g;
        logic       eol;
        logic       eof;
        int         t;
    } exp_t;

    exp_t        q[$];
    int          m_state;   // 0 idle, 1 run, 2 drain, 3 done
    int          m_acc;
    int          m_pop;
    int          cyc = 0;
    int unsigned m_stall;
    logic [7:0]  m_r, m_g, m_b;
    int          errors = 0;
    int          checks = 0;

    function automatic logic exp_in_ready();
        return (m_state == 1) && ((m_acc - m_pop) < D);
    endfunction

    function automatic logic exp_out_valid();
        return (q.size() > 0) && (cyc >= q[0].t + L + 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 0;
        m_acc   = 0;
        m_pop   = 0;
        m_stall = 0;
        m_r = '0; m_g = '0; m_b = '0;
    endtask

    task automatic model_edge();
        logic a, p;
        int   s;
        exp_t e;
        a = in_valid && exp_in_ready();
        p = out_ready && exp_out_valid();
        s = m_state;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (s == 1 && in_valid && !a && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (p) begin
                q.delete(0);
                m_pop++;
            end
            if (a) begin
                e.g   = gray_ref(in_r, in_g, in_b);
                e.eol = ((m_acc % W) == W - 1);
                e.eof = (m_acc == N - 1);
                e.t   = cyc;
                q.push_back(e);
                m_acc++;
                m_r = in_r; m_g = in_g; m_b = in_b;
            end
            case (s)
                0: if (start) begin m_state = 1; m_acc = 0; m_pop = 0; m_stall = 0; end
                1: if (m_acc == N) m_state = 2;
                2: if (m_pop == N) m_state = 3;
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("in_ready", 32'(in_ready), 32'(exp_in_ready()));
        chk("out_valid", 32'(out_valid), 32'(exp_out_valid()));
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("frame_done", 32'(frame_done), 32'(m_state == 3));
        chk("dp_r", 32'(dp_r), 32'(m_r));
        chk("dp_g", 32'(dp_g), 32'(m_g));
        chk("dp_b", 32'(dp_b), 32'(m_b));
        if (exp_out_valid()) begin
            chk("out_gray", 32'(out_gray), 32'(q[0].g));
            chk("out_eol", 32'(out_eol), 32'(q[0].eol));
            chk("out_eof", 32'(out_eof), 32'(q[0].eof));
        end
`ifdef GRAY_CTRL_STATS_EN
        chk("stall_cycles", stall_cycles, m_stall);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive_rand(input int pv, input int pr);
        in_valid  = ($urandom_range(99) < pv);
        out_ready = ($urandom_range(99) < pr);
        in_r = 8'($urandom);
        in_g = 8'($urandom);
        in_b = 8'($urandom);
    endtask

    task automatic finish_frame(input int pv, input int pr, input int max_cyc, input bit poke);
        int pulses = 0;
        int n = 0;
        while (m_state != 0 && n < max_cyc) begin
            drive_rand(pv, pr);
            start = poke && (m_acc == 5);
            tick();
            if (frame_done) pulses++;
            n++;
        end
        start = 1'b0;
        chk("frame_end_busy", 32'(busy), 32'd0);
        chk("frame_done_pulses", 32'(pulses), 32'd1);
    endtask

    task automatic begin_frame();
        start = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic reset_value_checks(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_dp_r"}, 32'(dp_r), 32'd0);
        chk({tag, "_dp_g"}, 32'(dp_g), 32'd0);
        chk({tag, "_dp_b"}, 32'(dp_b), 32'd0);
        chk({tag, "_out_gray"}, 32'(out_gray), 32'd0);
        chk({tag, "_out_eol"}, 32'(out_eol), 32'd0);
        chk({tag, "_out_eof"}, 32'(out_eof), 32'd0);
    endtask

    initial begin
        int k;
        int lat;
        model_reset();

        // power-on reset
        repeat (2) tick();
        reset_value_checks("por");
        rst = 1'b0;
        tick();

        // in_valid while idle is not accepted
        in_valid = 1'b1;
        in_r = 8'd10;
        repeat (3) tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // single pixel latency and value, then the rest of the frame with a stray start
        out_ready = 1'b1;
        begin_frame();
        in_valid = 1'b1;
        in_r = 8'd200; in_g = 8'd200; in_b = 8'd200;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("first_latency", 32'(lat), 32'd4);
        chk("gray_200", 32'(out_gray), 32'd197);
        finish_frame(100, 100, 200, 1'b1);

        // full frame streamed at full rate
        begin_frame();
        finish_frame(100, 100, 200, 1'b0);

        // consumer backpressure mid-frame
        begin_frame();
        k = 0;
        while (m_acc < 3 && k < 20) begin
            drive_rand(100, 100);
            tick();
            k++;
        end
        k = 0;
        while (in_ready && k < 20) begin
            drive_rand(100, 0);
            tick();
            k++;
        end
        chk("bp_credit_stop", 32'(in_ready), 32'd0);
        repeat (5) begin
            drive_rand(100, 0);
            tick();
        end
`ifdef GRAY_CTRL_STATS_EN
        chk("stall_five", stall_cycles, 32'd5);
`endif
        repeat (10) begin
            drive_rand(100, 0);
            tick();
        end
        chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
        finish_frame(100, 100, 200, 1'b0);

        // random traffic, back-to-back frames
        repeat (3) begin
            begin_frame();
            finish_frame(70, 60, 600, 1'b0);
        end

        // reset in the middle of a frame, then a clean frame
        out_ready = 1'b1;
        begin_frame();
        k = 0;
        while (m_acc < 3 && k < 20) begin
            drive_rand(100, 100);
            tick();
            k++;
        end
        rst = 1'b1;
        #1;
        reset_value_checks("midrst");
        model_reset();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        begin_frame();
        finish_frame(100, 100, 200, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
